// File: rtl/time_keeper.sv
// Time-of-day counter: accepts a packed {mode, hour, minute, second} preset and
// advances it once per TICK_DIV clocks, in 24-hour or 12-hour (with PM flag) mode.
module time_keeper #(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] time_preset,
  input  logic        load,
  input  logic        run,
  output logic [31:0] time_now,
  output logic        pm,
  output logic        sec_pulse,
  output logic        day_pulse,
  output logic        load_err
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    mode_q, mode_d;
  logic [7:0]    hour_q, hour_d;
  logic [7:0]    min_q, min_d;
  logic [7:0]    sec_q, sec_d;
  logic          pm_q, pm_d;
  logic          sec_pulse_q, sec_pulse_d;
  logic          day_pulse_q, day_pulse_d;
  logic          err_q, err_d;

  logic [7:0] p_mode, p_hour, p_min, p_sec;
  logic       preset_ok;
  logic       load_ok;
  logic       tick;

  assign p_mode = time_preset[31:24];
  assign p_hour = time_preset[23:16];
  assign p_min  = time_preset[15:8];
  assign p_sec  = time_preset[7:0];

  // Hour range is judged against the preset's own mode byte, not the stored one.
  assign preset_ok = (p_sec <= 8'd59) && (p_min <= 8'd59) &&
                     ((p_mode != 8'd0) ? (p_hour <= 8'd23)
                                       : ((p_hour >= 8'd1) && (p_hour <= 8'd12)));
  assign load_ok   = load && preset_ok;
  assign tick      = run && (presc_q == PRESC_MAX);

  always_comb begin
    presc_d     = presc_q;
    mode_d      = mode_q;
    hour_d      = hour_q;
    min_d       = min_q;
    sec_d       = sec_q;
    pm_d        = pm_q;
    sec_pulse_d = 1'b0;
    day_pulse_d = 1'b0;
    err_d       = err_q;

    if (run) begin
      presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
    end

    if (load && !preset_ok) begin
      err_d = 1'b1;
    end

    // A rejected load behaves as no load at all, so a coincident tick still lands.
    if (load_ok) begin
      mode_d  = p_mode;
      hour_d  = p_hour;
      min_d   = p_min;
      sec_d   = p_sec;
      pm_d    = 1'b0;
      presc_d = '0;
      err_d   = 1'b0;
    end else if (tick) begin
      sec_pulse_d = 1'b1;
      if (sec_q == 8'd59) begin
        sec_d = 8'd0;
        if (min_q == 8'd59) begin
          min_d = 8'd0;
          if (mode_q != 8'd0) begin
            if (hour_q == 8'd23) begin
              hour_d      = 8'd0;
              day_pulse_d = 1'b1;
            end else begin
              hour_d = hour_q + 8'd1;
            end
          end else begin
            if (hour_q == 8'd11) begin
              hour_d      = 8'd12;
              pm_d        = ~pm_q;
              day_pulse_d = pm_q;
            end else if (hour_q == 8'd12) begin
              hour_d = 8'd1;
            end else begin
              hour_d = hour_q + 8'd1;
            end
          end
        end else begin
          min_d = min_q + 8'd1;
        end
      end else begin
        sec_d = sec_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q     <= '0;
      mode_q      <= 8'h01;
      hour_q      <= '0;
      min_q       <= '0;
      sec_q       <= '0;
      pm_q        <= 1'b0;
      sec_pulse_q <= 1'b0;
      day_pulse_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      mode_q      <= mode_d;
      hour_q      <= hour_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      pm_q        <= pm_d;
      sec_pulse_q <= sec_pulse_d;
      day_pulse_q <= day_pulse_d;
      err_q       <= err_d;
    end
  end

  assign time_now  = {mode_q, hour_q, min_q, sec_q};
  assign pm        = pm_q;
  assign sec_pulse = sec_pulse_q;
  assign day_pulse = day_pulse_q;
  assign load_err  = err_q;

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper with TICK_DIV = 4; expected values hand-computed.
module tb_time_keeper;

  logic        clk;
  logic        reset;
  logic [31:0] time_preset;
  logic        load;
  logic        run;
  logic [31:0] time_now;
  logic        pm;
  logic        sec_pulse;
  logic        day_pulse;
  logic        load_err;

  int unsigned n_pass;
  int unsigned n_total;

  time_keeper #(.TICK_DIV(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .time_preset (time_preset),
    .load        (load),
    .run         (run),
    .time_now    (time_now),
    .pm          (pm),
    .sec_pulse   (sec_pulse),
    .day_pulse   (day_pulse),
    .load_err    (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic check_state(input string tag, input logic [31:0] t, input logic p,
                             input logic sp, input logic dp, input logic err);
    check({tag, ".time"}, time_now, t);
    check({tag, ".pm"}, {31'd0, pm}, {31'd0, p});
    check({tag, ".sec_pulse"}, {31'd0, sec_pulse}, {31'd0, sp});
    check({tag, ".day_pulse"}, {31'd0, day_pulse}, {31'd0, dp});
    check({tag, ".load_err"}, {31'd0, load_err}, {31'd0, err});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  task automatic load_word(input logic [31:0] w);
    time_preset = w;
    load        = 1'b1;
    step();
    load        = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_pass      = 0;
    n_total     = 0;
    reset       = 1'b1;
    load        = 1'b1;
    run         = 1'b1;
    time_preset = 32'h0117_3B3A;

    // reset beats a pending load
    steps(2);
    reset = 1'b0;
    load  = 1'b0;
    check_state("rst", 32'h0100_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    steps(3);
    check("rst_nosp", {31'd0, sec_pulse}, 32'd0);
    step();
    check_state("rst_first", 32'h0100_0001, 1'b0, 1'b1, 1'b0, 1'b0);

    // 24-hour day wrap
    load_word(32'h0117_3B3A);
    check_state("l24", 32'h0117_3B3A, 1'b0, 1'b0, 1'b0, 1'b0);
    steps(3);
    check("l24_nosp", {31'd0, sec_pulse}, 32'd0);
    step();
    check_state("t24a", 32'h0117_3B3B, 1'b0, 1'b1, 1'b0, 1'b0);
    steps(4);
    check_state("wrap24", 32'h0100_0000, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    check_state("wrap24_after", 32'h0100_0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // 12-hour: 11:59:59 AM -> 12:00:00 PM
    load_word(32'h000B_3B3B);
    steps(4);
    check_state("am_to_pm", 32'h000C_0000, 1'b1, 1'b1, 1'b0, 1'b0);

    // 12-hour: 12:59:59 AM -> 1:00:00 AM
    load_word(32'h000C_3B3B);
    check("l12_pm", {31'd0, pm}, 32'd0);
    steps(4);
    check_state("h12_to_1", 32'h0001_0000, 1'b0, 1'b1, 1'b0, 1'b0);

    // 12-hour: 11:59:59 PM -> 12:00:00 AM; PM state planted directly
    load_word(32'h000B_3B3B);
    force dut.pm_q = 1'b1;
    steps(4);
    check("pm_wrap.time", time_now, 32'h000C_0000);
    check("pm_wrap.sec_pulse", {31'd0, sec_pulse}, 32'd1);
    check("pm_wrap.day_pulse", {31'd0, day_pulse}, 32'd1);
    release dut.pm_q;

    // invalid presets
    load_word(32'h0101_0101);
    check_state("lv", 32'h0101_0101, 1'b0, 1'b0, 1'b0, 1'b0);
    load_word(32'h0118_0000);
    check_state("bad_h24", 32'h0101_0101, 1'b0, 1'b0, 1'b0, 1'b1);
    steps(2);
    check("bad_nosp", {31'd0, sec_pulse}, 32'd0);
    step();
    check_state("bad_counts", 32'h0101_0102, 1'b0, 1'b1, 1'b0, 1'b1);
    load_word(32'h0000_0000);
    check_state("bad_h0", 32'h0101_0102, 1'b0, 1'b0, 1'b0, 1'b1);
    load_word(32'h0100_003C);
    check_state("bad_s60", 32'h0101_0102, 1'b0, 1'b0, 1'b0, 1'b1);
    load_word(32'h0102_0304);
    check_state("err_clear", 32'h0102_0304, 1'b0, 1'b0, 1'b0, 1'b0);

    // load collides with a tick
    steps(3);
    load_word(32'h0101_0203);
    check_state("coll", 32'h0101_0203, 1'b0, 1'b0, 1'b0, 1'b0);
    steps(3);
    check("coll_nosp", {31'd0, sec_pulse}, 32'd0);
    step();
    check_state("coll_next", 32'h0101_0204, 1'b0, 1'b1, 1'b0, 1'b0);

    // load held high suppresses ticks
    time_preset = 32'h0100_0102;
    load        = 1'b1;
    steps(6);
    check_state("hold", 32'h0100_0102, 1'b0, 1'b0, 1'b0, 1'b0);
    load = 1'b0;
    steps(3);
    check("hold_nosp", {31'd0, sec_pulse}, 32'd0);
    step();
    check_state("hold_next", 32'h0100_0103, 1'b0, 1'b1, 1'b0, 1'b0);

    // run gating at prescaler = 2
    steps(2);
    run = 1'b0;
    steps(10);
    check_state("gated", 32'h0100_0103, 1'b0, 1'b0, 1'b0, 1'b0);
    run = 1'b1;
    step();
    check("resume_nosp", {31'd0, sec_pulse}, 32'd0);
    step();
    check_state("resume", 32'h0100_0104, 1'b0, 1'b1, 1'b0, 1'b0);

    // reset mid-count (prescaler = 1, load_err set)
    load_word(32'h0100_3C00);
    check_state("bad_m60", 32'h0100_0104, 1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_state("rst_mid", 32'h0100_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    steps(3);
    check("rst_mid_nosp", {31'd0, sec_pulse}, 32'd0);
    step();
    check_state("rst_mid_first", 32'h0100_0001, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
